// File: rtl/sd_pkg.sv
// Shared definitions for the SD device ring-bus blocks: event codes, completion record
// layout, event pointer field offsets and the reporter FSM encoding.
package sd_pkg;

  localparam logic [7:0] EVE_RD_DONE  = 8'h48;
  localparam logic [7:0] EVE_WR_DONE  = 8'h49;
  localparam logic [7:0] EVE_REG_DONE = 8'h4D;
  localparam logic [7:0] EVE_ERR      = 8'h4E;
  localparam logic [7:0] EVE_INIT     = 8'h4F;

  typedef enum logic [1:0] {
    KIND_RD   = 2'd0,
    KIND_WR   = 2'd1,
    KIND_REG  = 2'd2,
    KIND_RSVD = 2'd3
  } sd_kind_t;

  typedef struct packed {
    sd_kind_t    kind;
    logic        err;
    logic [7:0]  code;
    logic [15:0] blks;
  } sd_rec_t;

  localparam int REC_W = $bits(sd_rec_t);

  localparam int PTR_OVF  = 39;
  localparam int PTR_SEQ  = 32;
  localparam int PTR_BLKS = 16;
  localparam int PTR_CODE = 8;
  localparam int PTR_KIND = 6;
  localparam int PTR_LSB  = 0;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_LOAD      = 2'd1,
    ST_LOAD_INIT = 2'd2,
    ST_WAIT      = 2'd3
  } eve_state_t;

  // Any error outranks the operation kind in the reported command.
  function automatic logic [7:0] done_cmd(sd_rec_t r);
    if (r.err) return EVE_ERR;
    case (r.kind)
      KIND_WR:  return EVE_WR_DONE;
      KIND_REG: return EVE_REG_DONE;
      default:  return EVE_RD_DONE;
    endcase
  endfunction

  function automatic logic [39:0] pack_ptr(logic ovf, logic [6:0] seq, logic [15:0] blks,
                                           logic [7:0] code, logic [1:0] kind, logic lsb);
    logic [39:0] p;
    p = '0;
    p[PTR_OVF]       = ovf;
    p[PTR_SEQ +: 7]  = seq;
    p[PTR_BLKS +: 16] = blks;
    p[PTR_CODE +: 8] = code;
    p[PTR_KIND +: 2] = kind;
    p[PTR_LSB]       = lsb;
    return p;
  endfunction

endpackage

// File: rtl/sd_eve_fifo.sv
// Small synchronous FIFO for completion records; a pop in the same cycle frees a slot
// so a push into a full FIFO is still accepted.
module sd_eve_fifo #(
  parameter int AW = 2,
  parameter int W  = 27
) (
  input  logic         clk_sd,
  input  logic         rst_sd,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int DEPTH = 2 ** AW;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (AW + 1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rptr];

  always_ff @(posedge clk_sd) begin
    if (rst_sd) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) begin
        mem[wptr] <= wdata;
        wptr      <= wptr + 1'b1;
      end
      if (do_pop) rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sd_eve_reporter.sv
// Return-path event source: queues SD completions and card-ready changes and presents
// them one at a time as d2r events.  Handshake: eve_stb/dev/cmd/ptr hold until eve_ack=1
// is sampled with eve_stb=1; eve_ack while eve_stb=0 has no effect.
module sd_eve_reporter
  import sd_pkg::*;
#(
  parameter int         FIFO_AW     = 2,
  parameter logic [7:0] EVE_DEV_DEF = 8'h00
) (
  input  logic        clk_sd,
  input  logic        rst_sd,
  input  logic        sd_initialized,
  input  logic [7:0]  cfg_dev,
  input  logic        cfg_dev_vld,
  input  logic        sd_done_stb,
  input  logic [1:0]  sd_done_kind,
  input  logic        sd_done_err,
  input  logic [7:0]  sd_done_code,
  input  logic [15:0] sd_done_blks,
  output logic        eve_stb,
  output logic [7:0]  eve_dev,
  output logic [7:0]  eve_cmd,
  output logic [39:0] eve_ptr,
  input  logic        eve_ack,
  output logic [7:0]  ovf_cnt
);

  eve_state_t state;
  eve_state_t state_nxt;
  sd_rec_t    fifo_wdata;
  sd_rec_t    fifo_rdata;
  logic       fifo_full;
  logic       fifo_empty;
  logic       fifo_push;
  logic       fifo_pop;
  logic       done_vld;
  logic       drop;
  logic       ack_hs;
  logic       ld;
  logic       ld_init;
  logic       init_q;
  logic       init_chg;
  logic       pend_init;
  logic       cur_init;
  logic       ovf_flag;
  logic [6:0] seq;

  assign init_chg = sd_initialized ^ init_q;
  assign ack_hs   = eve_stb && eve_ack;
  assign fifo_pop = ack_hs && !cur_init;
  // Reserved-kind completions without error carry nothing worth reporting.
  assign done_vld  = sd_done_stb && !((sd_done_kind == KIND_RSVD) && !sd_done_err);
  assign fifo_push = done_vld && (!fifo_full || fifo_pop);
  assign drop      = done_vld && fifo_full && !fifo_pop;

  assign fifo_wdata = '{kind: sd_kind_t'(sd_done_kind), err: sd_done_err,
                        code: sd_done_code, blks: sd_done_blks};

  sd_eve_fifo #(.AW(FIFO_AW), .W(REC_W)) u_fifo (
    .clk_sd (clk_sd),
    .rst_sd (rst_sd),
    .push   (fifo_push),
    .pop    (fifo_pop),
    .wdata  (fifo_wdata),
    .rdata  (fifo_rdata),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  always_ff @(posedge clk_sd) begin
    if (rst_sd) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (pend_init)        state_nxt = ST_LOAD_INIT;
        else if (!fifo_empty) state_nxt = ST_LOAD;
      end
      ST_LOAD, ST_LOAD_INIT: state_nxt = ST_WAIT;
      ST_WAIT: if (ack_hs) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    ld      = (state == ST_LOAD) || (state == ST_LOAD_INIT);
    ld_init = (state == ST_LOAD_INIT);
  end

  always_ff @(posedge clk_sd) begin
    if (rst_sd) begin
      eve_stb  <= 1'b0;
      eve_dev  <= '0;
      eve_cmd  <= '0;
      eve_ptr  <= '0;
      cur_init <= 1'b0;
    end else if (ld) begin
      eve_stb  <= 1'b1;
      eve_dev  <= cfg_dev_vld ? cfg_dev : EVE_DEV_DEF;
      cur_init <= ld_init;
      eve_cmd  <= ld_init ? EVE_INIT : done_cmd(fifo_rdata);
      eve_ptr  <= ld_init ? pack_ptr(ovf_flag, seq, 16'h0, 8'h0, 2'd0, init_q)
                          : pack_ptr(ovf_flag, seq, fifo_rdata.blks, fifo_rdata.code,
                                     fifo_rdata.kind, fifo_rdata.err);
    end else if (ack_hs) begin
      eve_stb <= 1'b0;
    end
  end

  // A level change seen while its predecessor is in flight re-arms the init event.
  always_ff @(posedge clk_sd) begin
    if (rst_sd) begin
      seq       <= '0;
      ovf_flag  <= 1'b0;
      ovf_cnt   <= '0;
      init_q    <= 1'b0;
      pend_init <= 1'b0;
    end else begin
      init_q <= sd_initialized;
      if (ack_hs) seq <= seq + 7'd1;
      if (drop)                              ovf_flag <= 1'b1;
      else if (ack_hs && eve_ptr[PTR_OVF])   ovf_flag <= 1'b0;
      if (drop && (ovf_cnt != 8'hFF)) ovf_cnt <= ovf_cnt + 8'd1;
      if (init_chg)                pend_init <= 1'b1;
      else if (ack_hs && cur_init) pend_init <= (init_q != eve_ptr[PTR_LSB]);
    end
  end

endmodule

// File: tb/tb_sd_eve_reporter.sv
// Bench for sd_eve_reporter: directed steps plus a randomized phase, checked against a
// queue-based model of the completion records, overflow count/flag, sequence and init state.
module tb_sd_eve_reporter;

  logic        clk_sd = 1'b0;
  logic        rst_sd;
  logic        sd_initialized;
  logic [7:0]  cfg_dev;
  logic        cfg_dev_vld;
  logic        sd_done_stb;
  logic [1:0]  sd_done_kind;
  logic        sd_done_err;
  logic [7:0]  sd_done_code;
  logic [15:0] sd_done_blks;
  logic        eve_stb;
  logic [7:0]  eve_dev;
  logic [7:0]  eve_cmd;
  logic [39:0] eve_ptr;
  logic        eve_ack;
  logic [7:0]  ovf_cnt;

  sd_eve_reporter #(.FIFO_AW(2), .EVE_DEV_DEF(8'h00)) dut (
    .clk_sd         (clk_sd),
    .rst_sd         (rst_sd),
    .sd_initialized (sd_initialized),
    .cfg_dev        (cfg_dev),
    .cfg_dev_vld    (cfg_dev_vld),
    .sd_done_stb    (sd_done_stb),
    .sd_done_kind   (sd_done_kind),
    .sd_done_err    (sd_done_err),
    .sd_done_code   (sd_done_code),
    .sd_done_blks   (sd_done_blks),
    .eve_stb        (eve_stb),
    .eve_dev        (eve_dev),
    .eve_cmd        (eve_cmd),
    .eve_ptr        (eve_ptr),
    .eve_ack        (eve_ack),
    .ovf_cnt        (ovf_cnt)
  );

  always #5 clk_sd = ~clk_sd;

  int n_tests = 0;
  int n_fail  = 0;

  // Model state: records accepted and not yet acknowledged, {kind, err, code, blks}.
  logic [26:0] exp_q[$];
  int          m_ovf = 0;
  logic        m_flag = 1'b0;
  logic [6:0]  m_seq = 7'd0;
  logic        m_pend = 1'b0;
  logic        m_lvl = 1'b0;
  logic        prev_flag = 1'b0;
  logic [7:0]  dev_at_edge = 8'h00;
  logic        stb_seen = 1'b0;
  logic        cur_init = 1'b0;
  logic [7:0]  exp_cmd = 8'h00;
  logic [7:0]  exp_dev = 8'h00;
  logic [39:0] exp_ptr = 40'h0;
  int          starve = 0;

  task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] cmd_of(input logic [1:0] k, input logic e);
    if (e) return 8'h4E;
    case (k)
      2'd0:    return 8'h48;
      2'd1:    return 8'h49;
      default: return 8'h4D;
    endcase
  endfunction

  task automatic observe();
    logic [26:0] r;
    if (eve_stb && !stb_seen) begin
      exp_dev = dev_at_edge;
      if (m_pend) begin
        cur_init = 1'b1;
        exp_cmd  = 8'h4F;
        exp_ptr  = {prev_flag, m_seq, 31'h0, m_lvl};
      end else if (exp_q.size() > 0) begin
        r        = exp_q[0];
        cur_init = 1'b0;
        exp_cmd  = cmd_of(r[26:25], r[24]);
        exp_ptr  = {prev_flag, m_seq, r[15:0], r[23:16], r[26:25], 5'b0, r[24]};
      end else begin
        chk("spurious_stb", {39'h0, eve_stb}, 40'h0);
      end
    end
    if (eve_stb) begin
      chk("eve_cmd", {32'h0, eve_cmd}, {32'h0, exp_cmd});
      chk("eve_dev", {32'h0, eve_dev}, {32'h0, exp_dev});
      chk("eve_ptr", eve_ptr, exp_ptr);
      starve = 0;
    end else if (exp_q.size() > 0 || m_pend) begin
      starve++;
      if (starve > 3) begin
        chk("starve", {39'h0, eve_stb}, 40'h1);
        starve = 0;
      end
    end else begin
      starve = 0;
    end
    chk("ovf_cnt", {32'h0, ovf_cnt}, m_ovf[39:0]);
    stb_seen = eve_stb;
  endtask

  // One clock: apply the model's view of this edge, then sample at the falling edge.
  task automatic cyc();
    logic acked;
    acked       = stb_seen && eve_ack;
    prev_flag   = m_flag;
    dev_at_edge = cfg_dev_vld ? cfg_dev : 8'h00;
    if (rst_sd) begin
      exp_q.delete();
      m_ovf  = 0;
      m_flag = 1'b0;
      m_seq  = 7'd0;
      m_pend = 1'b0;
      m_lvl  = 1'b0;
    end else begin
      if (acked) begin
        if (cur_init) m_pend = 1'b0;
        else          void'(exp_q.pop_front());
        m_seq = m_seq + 7'd1;
        if (exp_ptr[39]) m_flag = 1'b0;
      end
      if (sd_done_stb && !(sd_done_kind == 2'd3 && !sd_done_err)) begin
        if (exp_q.size() < 4) begin
          exp_q.push_back({sd_done_kind, sd_done_err, sd_done_code, sd_done_blks});
        end else begin
          if (m_ovf < 255) m_ovf++;
          m_flag = 1'b1;
        end
      end
      if (sd_initialized != m_lvl) begin
        m_lvl  = sd_initialized;
        m_pend = 1'b1;
      end
    end
    @(posedge clk_sd);
    @(negedge clk_sd);
    observe();
  endtask

  task automatic drive_done(input logic [1:0] k, input logic e, input logic [7:0] c,
                            input logic [15:0] b);
    sd_done_stb  = 1'b1;
    sd_done_kind = k;
    sd_done_err  = e;
    sd_done_code = c;
    sd_done_blks = b;
    cyc();
    sd_done_stb = 1'b0;
  endtask

  task automatic wait_stb(input string tag);
    int n;
    n = 0;
    while (!stb_seen && n < 8) begin
      cyc();
      n++;
    end
    chk(tag, {39'h0, stb_seen}, 40'h1);
  endtask

  task automatic ack_now();
    eve_ack = 1'b1;
    cyc();
    eve_ack = 1'b0;
    chk("stb_after_ack", {39'h0, eve_stb}, 40'h0);
  endtask

  initial begin
    rst_sd = 1'b1; sd_initialized = 1'b0; cfg_dev = 8'h00; cfg_dev_vld = 1'b0;
    sd_done_stb = 1'b0; sd_done_kind = 2'd0; sd_done_err = 1'b0;
    sd_done_code = 8'h00; sd_done_blks = 16'h0; eve_ack = 1'b0;
    cyc(); cyc();
    rst_sd = 1'b0;
    chk("rst_stb", {39'h0, eve_stb}, 40'h0);
    chk("rst_dev", {32'h0, eve_dev}, 40'h0);
    chk("rst_cmd", {32'h0, eve_cmd}, 40'h0);
    chk("rst_ptr", eve_ptr, 40'h0);
    chk("rst_ovf", {32'h0, ovf_cnt}, 40'h0);

    // Read done, exact two-cycle latency.
    drive_done(2'd0, 1'b0, 8'h00, 16'h0008);
    chk("t1_lat0", {39'h0, eve_stb}, 40'h0);
    cyc();
    chk("t1_lat1", {39'h0, eve_stb}, 40'h0);
    cyc();
    chk("t1_lat2", {39'h0, eve_stb}, 40'h1);
    chk("t1_cmd", {32'h0, eve_cmd}, 40'h48);
    chk("t1_blks", {24'h0, eve_ptr[31:16]}, 40'h8);
    chk("t1_seq", {33'h0, eve_ptr[38:32]}, 40'h0);
    ack_now();

    // Write done with error.
    drive_done(2'd1, 1'b1, 8'h5A, 16'($urandom));
    wait_stb("t2_stb");
    chk("t2_cmd", {32'h0, eve_cmd}, 40'h4E);
    chk("t2_code", {32'h0, eve_ptr[15:8]}, 40'h5A);
    chk("t2_kind", {38'h0, eve_ptr[7:6]}, 40'h1);
    chk("t2_err", {39'h0, eve_ptr[0]}, 40'h1);
    ack_now();

    // Overflow while ack is held low.
    for (int i = 0; i < 6; i++) drive_done(2'(i % 3), 1'b0, 8'(i), 16'(i + 1));
    chk("t3_ovf_cnt", {32'h0, ovf_cnt}, 40'h2);
    ack_now();
    wait_stb("t3_b_stb");
    chk("t3_b_ovf", {39'h0, eve_ptr[39]}, 40'h1);
    ack_now();
    wait_stb("t3_c_stb");
    chk("t3_c_ovf", {39'h0, eve_ptr[39]}, 40'h0);
    ack_now();
    wait_stb("t3_d_stb");
    ack_now();

    // Card-ready change arrives together with two records; init goes first.
    sd_initialized = 1'b1;
    drive_done(2'd2, 1'b0, 8'h11, 16'h0001);
    drive_done(2'd0, 1'b0, 8'h22, 16'h0002);
    wait_stb("t4_init_stb");
    chk("t4_init_cmd", {32'h0, eve_cmd}, 40'h4F);
    chk("t4_init_lvl", {39'h0, eve_ptr[0]}, 40'h1);
    ack_now();
    wait_stb("t4_a_stb");
    chk("t4_a_cmd", {32'h0, eve_cmd}, 40'h4D);
    ack_now();
    wait_stb("t4_b_stb");
    chk("t4_b_cmd", {32'h0, eve_cmd}, 40'h48);
    ack_now();

    // Randomized traffic, including drops and push/pop on a full FIFO.
    for (int i = 0; i < 400; i++) begin
      sd_done_stb  = ($urandom_range(0, 1) == 1);
      sd_done_kind = 2'($urandom_range(0, 3));
      sd_done_err  = ($urandom_range(0, 3) == 0);
      sd_done_code = 8'($urandom);
      sd_done_blks = 16'($urandom);
      eve_ack      = ($urandom_range(0, 1) == 1);
      cfg_dev_vld  = ($urandom_range(0, 1) == 1);
      cfg_dev      = 8'($urandom);
      cyc();
    end
    sd_done_stb = 1'b0;
    eve_ack     = 1'b1;
    for (int i = 0; i < 60 && (exp_q.size() > 0 || stb_seen); i++) cyc();
    eve_ack = 1'b0;
    cyc();
    chk("drain_done", {39'h0, eve_stb}, 40'h0);

    // Bring the sequence to 127, then a long-held event and the wrap.
    cfg_dev_vld = 1'b0;
    for (int i = 0; i < 130 && m_seq != 7'd127; i++) begin
      drive_done(2'd1, 1'b0, 8'h33, 16'($urandom));
      wait_stb("seq_stb");
      ack_now();
    end
    cfg_dev_vld = 1'b1;
    cfg_dev     = 8'hA5;
    drive_done(2'd0, 1'b0, 8'h44, 16'h0010);
    wait_stb("t5_stb");
    chk("t5_dev", {32'h0, eve_dev}, 40'hA5);
    chk("t5_seq", {33'h0, eve_ptr[38:32]}, 40'd127);
    for (int i = 0; i < 10; i++) begin
      cfg_dev = 8'($urandom_range(0, 255));
      cyc();
    end
    chk("t5_dev_hold", {32'h0, eve_dev}, 40'hA5);
    chk("t5_stb_hold", {39'h0, eve_stb}, 40'h1);
    ack_now();
    drive_done(2'd1, 1'b0, 8'h55, 16'h0020);
    wait_stb("t5_wrap_stb");
    chk("t5_wrap", {33'h0, eve_ptr[38:32]}, 40'h0);
    ack_now();

    // Reset while an event waits with three records queued.
    for (int i = 0; i < 6; i++) drive_done(2'd0, 1'b0, 8'(i), 16'(i));
    chk("t6_pre_stb", {39'h0, eve_stb}, 40'h1);
    rst_sd         = 1'b1;
    sd_initialized = 1'b0;
    cyc();
    rst_sd = 1'b0;
    chk("t6_rst_stb", {39'h0, eve_stb}, 40'h0);
    chk("t6_rst_ovf", {32'h0, ovf_cnt}, 40'h0);
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk("t6_quiet", {39'h0, eve_stb}, 40'h0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
